// File: rtl/leb128_encoder_pkg.sv
// Shared type codes, LEB128 length limits and capture helper for the immediate encoder.
package leb128_pkg;

  typedef enum logic [1:0] {
    TYPE_I32 = 2'd0,
    TYPE_I64 = 2'd1,
    TYPE_F32 = 2'd2,
    TYPE_F64 = 2'd3
  } val_type_e;

  localparam int LEB_MAX_I32 = 5;
  localparam int LEB_MAX_I64 = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } enc_state_e;

  // Widen an i32 to 64 bits so one shifter serves both integer widths.
  function automatic logic [63:0] extend_value(input logic [63:0] v, input val_type_e t,
                                               input logic s);
    logic [63:0] r;
    r = v;
    if (t == TYPE_I32) begin
      r = s ? {{32{v[31]}}, v[31:0]} : {32'd0, v[31:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/leb128_encoder_step.sv
// Combinational single-byte step: produces the next output byte, the shifted remainder
// and whether this byte terminates the value.
module leb128_step
  import leb128_pkg::*;
(
  input  logic [63:0] i_sh,
  input  logic        i_signed,
  input  val_type_e   i_type,
  input  logic [3:0]  i_idx,
  input  logic        i_pad,
  output logic [7:0]  o_byte,
  output logic [63:0] o_next_sh,
  output logic        o_last
);

  logic [6:0]  w_low;
  logic [63:0] w_next;
  logic        w_is_float;
  logic [3:0]  w_cap_idx;
  logic        w_cap;
  logic        w_natural;

  always_comb begin
    w_low      = i_sh[6:0];
    w_is_float = (i_type == TYPE_F32) || (i_type == TYPE_F64);
    case (i_type)
      TYPE_I32: w_cap_idx = 4'(LEB_MAX_I32 - 1);
      TYPE_I64: w_cap_idx = 4'(LEB_MAX_I64 - 1);
      TYPE_F32: w_cap_idx = 4'd3;
      default:  w_cap_idx = 4'd7;
    endcase
    w_cap = (i_idx == w_cap_idx);

    if (w_is_float)    w_next = {8'd0, i_sh[63:8]};
    else if (i_signed) w_next = {{7{i_sh[63]}}, i_sh[63:7]};
    else               w_next = {7'd0, i_sh[63:7]};

    // Signed values end once the remainder is pure sign and the emitted sign bit agrees.
    if (i_signed) w_natural = ((w_next == '0) && !w_low[6]) || ((w_next == '1) && w_low[6]);
    else          w_natural = (w_next == '0);

    o_next_sh = w_next;
    if (w_is_float) begin
      o_byte = i_sh[7:0];
      o_last = w_cap;
    end else begin
      o_last = i_pad ? w_cap : (w_natural || w_cap);
      o_byte = {~o_last, w_low};
    end
  end

endmodule

// File: rtl/leb128_encoder.sv
// Serialises one typed value into LEB128 / raw IEEE bytes, one byte per handshake.
// Build option LEB128_PAD_EN adds in_pad for fixed-width (5/10 byte) integer immediates.
module leb128_encoder
  import leb128_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_value,
  input  logic [1:0]  in_type,
  input  logic        in_signed,
`ifdef LEB128_PAD_EN
  input  logic        in_pad,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_last
);

  enc_state_e  r_state, w_state_next;
  logic [63:0] r_sh, w_sh_next;
  logic        r_signed, w_signed_next;
  val_type_e   r_type, w_type_next;
  logic        r_pad, w_pad_next;
  logic [3:0]  r_idx, w_idx_next;
  logic        r_in_ready, r_out_valid;
  logic [7:0]  r_out_byte, w_out_byte_next;
  logic        r_out_last, w_out_last_next;

  val_type_e   w_in_type;
  logic        w_in_pad;
  logic        w_idle;
  logic [63:0] w_step_sh;
  logic        w_step_signed;
  val_type_e   w_step_type;
  logic        w_step_pad;
  logic [3:0]  w_step_idx;
  logic [7:0]  w_step_byte;
  logic [63:0] w_step_next_sh;
  logic        w_step_last;

  assign w_in_type = val_type_e'(in_type);
`ifdef LEB128_PAD_EN
  assign w_in_pad = in_pad;
`else
  assign w_in_pad = 1'b0;
`endif

  // The step logic sees the incoming value while idle so the first byte is ready on accept.
  assign w_idle        = (r_state == ST_IDLE);
  assign w_step_sh     = w_idle ? extend_value(in_value, w_in_type, in_signed) : r_sh;
  assign w_step_signed = w_idle ? in_signed : r_signed;
  assign w_step_type   = w_idle ? w_in_type : r_type;
  assign w_step_pad    = w_idle ? w_in_pad : r_pad;
  assign w_step_idx    = w_idle ? 4'd0 : r_idx;

  leb128_step u_step (
    .i_sh      (w_step_sh),
    .i_signed  (w_step_signed),
    .i_type    (w_step_type),
    .i_idx     (w_step_idx),
    .i_pad     (w_step_pad),
    .o_byte    (w_step_byte),
    .o_next_sh (w_step_next_sh),
    .o_last    (w_step_last)
  );

  always_comb begin
    w_state_next    = r_state;
    w_sh_next       = r_sh;
    w_signed_next   = r_signed;
    w_type_next     = r_type;
    w_pad_next      = r_pad;
    w_idx_next      = r_idx;
    w_out_byte_next = r_out_byte;
    w_out_last_next = r_out_last;
    case (r_state)
      ST_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_state_next    = ST_EMIT;
          w_sh_next       = w_step_next_sh;
          w_signed_next   = in_signed;
          w_type_next     = w_in_type;
          w_pad_next      = w_in_pad;
          w_idx_next      = 4'd1;
          w_out_byte_next = w_step_byte;
          w_out_last_next = w_step_last;
        end
      end
      default: begin
        if (out_ready) begin
          if (r_out_last) begin
            w_state_next    = ST_IDLE;
            w_idx_next      = 4'd0;
            w_out_byte_next = 8'd0;
            w_out_last_next = 1'b0;
          end else begin
            w_sh_next       = w_step_next_sh;
            w_idx_next      = r_idx + 4'd1;
            w_out_byte_next = w_step_byte;
            w_out_last_next = w_step_last;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_sh        <= '0;
      r_signed    <= 1'b0;
      r_type      <= TYPE_I32;
      r_pad       <= 1'b0;
      r_idx       <= 4'd0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_byte  <= 8'd0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_sh        <= w_sh_next;
      r_signed    <= w_signed_next;
      r_type      <= w_type_next;
      r_pad       <= w_pad_next;
      r_idx       <= w_idx_next;
      r_in_ready  <= (w_state_next == ST_IDLE);
      r_out_valid <= (w_state_next == ST_EMIT);
      r_out_byte  <= w_out_byte_next;
      r_out_last  <= w_out_last_next;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_byte  = r_out_byte;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_leb128_encoder.sv
// Self-checking bench for leb128_encoder: directed vectors, reference encoder model,
// per-cycle output scoreboard, backpressure and mid-stream reset.
module tb_leb128_encoder;
  import leb128_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_value;
  logic [1:0]  in_type;
  logic        in_signed;
`ifdef LEB128_PAD_EN
  logic        in_pad;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  bit   bp_en = 1'b0;
  bit   prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'd0;

  leb128_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_type   (in_type),
    .in_signed (in_signed),
`ifdef LEB128_PAD_EN
    .in_pad    (in_pad),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    out_ready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference encoder written from the byte-format rules, not the hardware structure.
  function automatic void model(input logic [63:0] v, input val_type_e t, input logic s,
                                input logic p, output logic [7:0] q[$]);
    longint     sv;
    int         si;
    logic [63:0] u;
    logic [6:0] b7;
    bit         more;
    int         maxn;
    q = {};
    if (t == TYPE_F32 || t == TYPE_F64) begin
      for (int i = 0; i < ((t == TYPE_F32) ? 4 : 8); i++) q.push_back(v[8*i +: 8]);
      return;
    end
    maxn = (t == TYPE_I32) ? 5 : 10;
    si = v[31:0];
    sv = (t == TYPE_I32) ? longint'(si) : longint'(v);
    u  = (t == TYPE_I32) ? {32'd0, v[31:0]} : v;
    for (int i = 0; i < maxn; i++) begin
      if (s) begin
        b7 = sv[6:0];
        sv = sv >>> 7;
        more = !((sv == 0 && !b7[6]) || (sv == -1 && b7[6]));
      end else begin
        b7 = u[6:0];
        u = u >> 7;
        more = (u != 0);
      end
      if (p) more = (i < maxn - 1);
      else if (i == maxn - 1) more = 1'b0;
      q.push_back({more, b7});
      if (!more) break;
    end
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_byte: got %0h want none", out_byte);
      end else begin
        chk("out_byte", {72'd0, out_byte}, {72'd0, exp_q[0]});
        chk("out_last", {79'd0, out_last}, {79'd0, (exp_q.size() == 1)});
        if (out_ready) void'(exp_q.pop_front());
      end
      if (prev_stall) chk("stall_hold", {72'd0, out_byte}, {72'd0, prev_byte});
    end
    prev_stall = (reset === 1'b1) && (out_valid === 1'b1) && !out_ready;
    prev_byte  = out_byte;
  end

  task automatic accept_only(input logic [63:0] v, input val_type_e t, input logic s,
                             input logic p);
    logic [7:0] q[$];
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_wait", {79'd0, in_ready}, 80'd1);
    in_valid  = 1'b1;
    in_value  = v;
    in_type   = t;
    in_signed = s;
`ifdef LEB128_PAD_EN
    in_pad    = p;
`endif
    model(v, t, s, p, q);
    foreach (q[i]) exp_q.push_back(q[i]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("first_valid", {79'd0, out_valid}, 80'd1);
    chk("busy_ready", {79'd0, in_ready}, 80'd0);
  endtask

  task automatic vec(input string name, input logic [63:0] v, input val_type_e t,
                     input logic s, input logic p, input logic [79:0] lit, input int nb);
    logic [7:0] q[$];
    logic [79:0] qp;
    int n;
    model(v, t, s, p, q);
    qp = '0;
    foreach (q[i]) if (i < 10) qp[8*i +: 8] = q[i];
    chk({name, "_len"}, 80'(q.size()), 80'(nb));
    chk({name, "_bytes"}, qp, lit);
    accept_only(v, t, s, p);
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk({name, "_drain"}, 80'(exp_q.size()), 80'd0);
    chk({name, "_ready_back"}, {79'd0, in_ready}, 80'd1);
    chk({name, "_idle_valid"}, {79'd0, out_valid}, 80'd0);
    $display("vector %s done", name);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_value = '0; in_type = 2'd0; in_signed = 1'b0;
    out_ready = 1'b1;
`ifdef LEB128_PAD_EN
    in_pad = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {79'd0, in_ready}, 80'd0);
    chk("rst_out_valid", {79'd0, out_valid}, 80'd0);
    chk("rst_out_byte", {72'd0, out_byte}, 80'd0);
    chk("rst_out_last", {79'd0, out_last}, 80'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", {79'd0, in_ready}, 80'd1);

    vec("u32_3", 64'd3, TYPE_I32, 1'b0, 1'b0, 80'h03, 1);
    vec("u32_624485", 64'd624485, TYPE_I32, 1'b0, 1'b0, 80'h26_8E_E5, 3);
    vec("s32_m123456", 64'hDEAD_BEEF_FFFE_1DC0, TYPE_I32, 1'b1, 1'b0, 80'h78_BB_C0, 3);
    vec("s32_m1", 64'h0000_0000_FFFF_FFFF, TYPE_I32, 1'b1, 1'b0, 80'h7F, 1);
    vec("s32_64", 64'd64, TYPE_I32, 1'b1, 1'b0, 80'h00_C0, 2);
    vec("u64_max", 64'hFFFF_FFFF_FFFF_FFFF, TYPE_I64, 1'b0, 1'b0,
        80'h01_FF_FF_FF_FF_FF_FF_FF_FF_FF, 10);
    vec("f32_one", 64'h1234_5678_3F80_0000, TYPE_F32, 1'b0, 1'b0, 80'h3F_80_00_00, 4);
    vec("f64_one", 64'h3FF0_0000_0000_0000, TYPE_F64, 1'b1, 1'b0,
        80'h3F_F0_00_00_00_00_00_00, 8);

    bp_en = 1'b1;
    vec("bp_624485", 64'd624485, TYPE_I32, 1'b0, 1'b0, 80'h26_8E_E5, 3);
    vec("bp_s64_m123456", 64'hFFFF_FFFF_FFFE_1DC0, TYPE_I64, 1'b1, 1'b0, 80'h78_BB_C0, 3);
    bp_en = 1'b0;
    @(posedge clk); #1;

    accept_only(64'd624485, TYPE_I32, 1'b0, 1'b0);
    reset = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    chk("abort_valid", {79'd0, out_valid}, 80'd0);
    chk("abort_last", {79'd0, out_last}, 80'd0);
    chk("abort_ready", {79'd0, in_ready}, 80'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    vec("post_rst_3", 64'd3, TYPE_I32, 1'b0, 1'b0, 80'h03, 1);

`ifdef LEB128_PAD_EN
    vec("pad_u32_3", 64'd3, TYPE_I32, 1'b0, 1'b1, 80'h00_80_80_80_83, 5);
    vec("pad_s32_m1", 64'h0000_0000_FFFF_FFFF, TYPE_I32, 1'b1, 1'b1, 80'h7F_FF_FF_FF_FF, 5);
    vec("pad_f32", 64'h3F80_0000, TYPE_F32, 1'b0, 1'b1, 80'h3F_80_00_00, 4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
